// File: rtl/pc_ds_parser_pkg.sv
// Shared PC-interface definitions: host word layout (route | code | data,
// MSB first), reserved route/code values, word classification and the
// skid-FIFO occupancy states.
package pc_ds_parser_pkg;

  localparam int ROUTE_W = 5;
  localparam int CODE_W  = 7;
  localparam int DATA_W  = 20;
  localparam int WORD_W  = ROUTE_W + CODE_W + DATA_W;

  localparam int GO_HOME_RT_DEF    = 31;
  localparam int NOP_CODE_DEF      = 64;
  localparam int DS_QUEUE_CODE_DEF = 65;

  typedef struct packed {
    logic [ROUTE_W-1:0] route;
    logic [CODE_W-1:0]  code;
    logic [DATA_W-1:0]  data;
  } pc_word_t;

  typedef enum logic [2:0] {
    W_BD,
    W_REG,
    W_NOP,
    W_MARK,
    W_ILL
  } word_class_t;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } fifo_state_t;

  // Anything not routed home goes to the chip; home words are decoded by code.
  function automatic word_class_t classify(input pc_word_t w, input int go_home,
                                           input int nreg, input int nop,
                                           input int dsq);
    if (int'(w.route) != go_home) return W_BD;
    if (int'(w.code) < nreg)      return W_REG;
    if (int'(w.code) == nop)      return W_NOP;
    if (int'(w.code) == dsq)      return W_MARK;
    return W_ILL;
  endfunction

endpackage

// File: rtl/pc_skid_fifo.sv
// Two-entry skid buffer. The upstream ack is a register, so no combinational
// path runs from out_a back to in_a.
//
// state | meaning
// EMPTY | no word held, out_v = 0
// ONE   | head word valid on out_d, room for one more
// TWO   | both entries full, in_a = 0
module pc_skid_fifo
  import pc_ds_parser_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_v,
  output logic         in_a,
  input  logic [W-1:0] in_d,
  output logic         out_v,
  input  logic         out_a,
  output logic [W-1:0] out_d
);

  fifo_state_t  state;
  logic [W-1:0] mem0;
  logic [W-1:0] mem1;
  logic         push;
  logic         pop;

  assign push  = in_v & in_a;
  assign pop   = out_v & out_a;
  assign out_d = mem0;

  // Occupancy FSM with registered handshake outputs; mem0 is always the head.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      out_v <= 1'b0;
      in_a  <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          in_a <= 1'b1;
          if (push) begin
            mem0  <= in_d;
            state <= ONE;
            out_v <= 1'b1;
          end
        end
        ONE: begin
          in_a  <= 1'b1;
          out_v <= 1'b1;
          case ({push, pop})
            2'b10: begin
              mem1  <= in_d;
              state <= TWO;
              in_a  <= 1'b0;
            end
            2'b01: begin
              state <= EMPTY;
              out_v <= 1'b0;
            end
            2'b11: mem0 <= in_d;
            default: ;
          endcase
        end
        TWO: begin
          if (pop) begin
            mem0  <= mem1;
            state <= ONE;
            in_a  <= 1'b1;
          end
        end
        default: begin
          state <= EMPTY;
          out_v <= 1'b0;
          in_a  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pc_ds_parser.sv
// Host downstream parser: splits host words into chip-bound traffic (through
// a skid FIFO), FPGA register writes, DS-queue markers and dropped words.
// Define PC_DS_PARSER_STATS_EN to add NOP / illegal word counters.
module pc_ds_parser
  import pc_ds_parser_pkg::*;
#(
  parameter int NPC           = WORD_W,
  parameter int NREG          = 16,
  parameter int GO_HOME_RT    = GO_HOME_RT_DEF,
  parameter int NOP_CODE      = NOP_CODE_DEF,
  parameter int DS_QUEUE_CODE = DS_QUEUE_CODE_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         PC_in_v,
  output logic                         PC_in_a,
  input  logic [NPC-1:0]               PC_in_d,
  output logic                         BD_out_v,
  input  logic                         BD_out_a,
  output logic [NPC-1:0]               BD_out_d,
  output logic [NREG-1:0][DATA_W-1:0]  conf_reg,
  output logic                         ds_marker_v,
  output logic [DATA_W-1:0]            ds_marker_d
`ifdef PC_DS_PARSER_STATS_EN
  ,
  output logic [15:0]                  nop_count,
  output logic [15:0]                  illegal_count
`endif
);

  pc_word_t    word;
  word_class_t cls;
  logic        accept;

  assign word   = PC_in_d;
  assign cls    = classify(word, GO_HOME_RT, NREG, NOP_CODE, DS_QUEUE_CODE);
  assign accept = PC_in_v & PC_in_a;

  // Every class shares the FIFO's ack, so home words never stall on type.
  pc_skid_fifo #(.W(NPC)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .in_v  (PC_in_v & (cls == W_BD)),
    .in_a  (PC_in_a),
    .in_d  (PC_in_d),
    .out_v (BD_out_v),
    .out_a (BD_out_a),
    .out_d (BD_out_d)
  );

  // Register writes land on the accept edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      conf_reg <= '0;
    end else if (accept && cls == W_REG) begin
      for (int i = 0; i < NREG; i++) begin
        if (int'(word.code) == i) conf_reg[i] <= word.data;
      end
    end
  end

  // One-cycle marker pulse; payload holds its last value between markers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ds_marker_v <= 1'b0;
      ds_marker_d <= '0;
    end else begin
      ds_marker_v <= accept && cls == W_MARK;
      if (accept && cls == W_MARK) ds_marker_d <= word.data;
    end
  end

`ifdef PC_DS_PARSER_STATS_EN
  // Saturating counters of dropped words.
  always_ff @(posedge clk) begin
    if (reset) begin
      nop_count     <= '0;
      illegal_count <= '0;
    end else begin
      if (accept && cls == W_NOP && nop_count != 16'hFFFF)
        nop_count <= nop_count + 16'd1;
      if (accept && cls == W_ILL && illegal_count != 16'hFFFF)
        illegal_count <= illegal_count + 16'd1;
    end
  end
`else
  // Statistics not built; NOP and illegal words simply vanish.
`endif

endmodule

// File: tb/tb_pc_ds_parser.sv
// Directed bench for pc_ds_parser plus a BD-stream scoreboard under random
// traffic. Counter checks are active when PC_DS_PARSER_STATS_EN is defined.
module tb_pc_ds_parser;

  logic              clk = 1'b0;
  logic              reset;
  logic              PC_in_v;
  logic              PC_in_a;
  logic [31:0]       PC_in_d;
  logic              BD_out_v;
  logic              BD_out_a;
  logic [31:0]       BD_out_d;
  logic [15:0][19:0] conf_reg;
  logic              ds_marker_v;
  logic [19:0]       ds_marker_d;
`ifdef PC_DS_PARSER_STATS_EN
  logic [15:0]       nop_count;
  logic [15:0]       illegal_count;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  pc_ds_parser dut (
    .clk         (clk),
    .reset       (reset),
    .PC_in_v     (PC_in_v),
    .PC_in_a     (PC_in_a),
    .PC_in_d     (PC_in_d),
    .BD_out_v    (BD_out_v),
    .BD_out_a    (BD_out_a),
    .BD_out_d    (BD_out_d),
    .conf_reg    (conf_reg),
    .ds_marker_v (ds_marker_v),
    .ds_marker_d (ds_marker_d)
`ifdef PC_DS_PARSER_STATS_EN
    ,
    .nop_count     (nop_count),
    .illegal_count (illegal_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: at each edge, pop first (latency is one cycle), then record BD accepts.
  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (BD_out_v && BD_out_a) begin
        if (exp_q.size() == 0) chk("bd_extra", 32'(exp_q.size()), 32'd1);
        else chk("bd_stream", BD_out_d, exp_q.pop_front());
      end
      if (PC_in_v && PC_in_a && PC_in_d[31:27] != 5'd31) exp_q.push_back(PC_in_d);
    end
  end

  initial begin
    logic [31:0] others;
    reset    = 1'b1;
    PC_in_v  = 1'b0;
    PC_in_d  = '0;
    BD_out_a = 1'b0;
    tick();
    tick();
    chk("rst_in_a", 32'(PC_in_a), 32'd0);
    chk("rst_out_v", 32'(BD_out_v), 32'd0);
    chk("rst_mark_v", 32'(ds_marker_v), 32'd0);
    chk("rst_mark_d", 32'(ds_marker_d), 32'd0);
    chk("rst_conf", 32'(conf_reg != '0), 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_in_a", 32'(PC_in_a), 32'd1);

    // NOP burst
    PC_in_v = 1'b1;
    PC_in_d = 32'hFC000000;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("nop_in_a", 32'(PC_in_a), 32'd1);
      chk("nop_out_v", 32'(BD_out_v), 32'd0);
    end
    PC_in_v = 1'b0;
`ifdef PC_DS_PARSER_STATS_EN
    chk("nop_count", 32'(nop_count), 32'd8);
`endif

    // Register write to conf_reg[3]
    PC_in_v = 1'b1;
    PC_in_d = 32'hF83ABCDE;
    tick();
    PC_in_v = 1'b0;
    chk("conf3", 32'(conf_reg[3]), 32'h000ABCDE);
    others = '0;
    for (int i = 0; i < 16; i++) if (i != 3) others |= 32'(conf_reg[i]);
    chk("conf_others", others, 32'd0);

    // DS-queue marker
    PC_in_v = 1'b1;
    PC_in_d = 32'hFC100042;
    tick();
    PC_in_v = 1'b0;
    chk("mark_v", 32'(ds_marker_v), 32'd1);
    chk("mark_d", 32'(ds_marker_d), 32'h00042);
    tick();
    chk("mark_pulse_end", 32'(ds_marker_v), 32'd0);

    // Illegal code 20
    PC_in_v = 1'b1;
    PC_in_d = 32'hF9400000;
    tick();
    PC_in_v = 1'b0;
    chk("ill_conf3", 32'(conf_reg[3]), 32'h000ABCDE);
    others = '0;
    for (int i = 0; i < 16; i++) if (i != 3) others |= 32'(conf_reg[i]);
    chk("ill_conf_others", others, 32'd0);
    chk("ill_out_v", 32'(BD_out_v), 32'd0);
`ifdef PC_DS_PARSER_STATS_EN
    chk("illegal_count", 32'(illegal_count), 32'd1);
`endif

    // Backpressure: three BD words with BD_out_a low
    BD_out_a = 1'b0;
    PC_in_v  = 1'b1;
    PC_in_d  = 32'h28212345;
    tick();
    chk("bp1_out_v", 32'(BD_out_v), 32'd1);
    chk("bp1_out_d", BD_out_d, 32'h28212345);
    chk("bp1_in_a", 32'(PC_in_a), 32'd1);
    PC_in_d = 32'h28212346;
    tick();
    chk("bp2_in_a", 32'(PC_in_a), 32'd0);
    chk("bp2_out_d", BD_out_d, 32'h28212345);
    PC_in_d = 32'h28212347;
    tick();
    chk("bp3_in_a", 32'(PC_in_a), 32'd0);
    chk("bp3_hold_d", BD_out_d, 32'h28212345);
    BD_out_a = 1'b1;
    tick();
    chk("bp4_out_d", BD_out_d, 32'h28212346);
    chk("bp4_in_a", 32'(PC_in_a), 32'd1);
    tick();
    PC_in_v = 1'b0;
    chk("bp5_out_d", BD_out_d, 32'h28212347);
    tick();
    chk("bp6_out_v", 32'(BD_out_v), 32'd0);
    chk("bp_drained", 32'(exp_q.size()), 32'd0);

    // Reset while the FIFO is full
    BD_out_a = 1'b0;
    PC_in_v  = 1'b1;
    PC_in_d  = 32'h11111111;
    tick();
    PC_in_d  = 32'h22222222;
    tick();
    chk("full_in_a", 32'(PC_in_a), 32'd0);
    PC_in_v = 1'b0;
    reset   = 1'b1;
    tick();
    chk("midrst_out_v", 32'(BD_out_v), 32'd0);
    chk("midrst_in_a", 32'(PC_in_a), 32'd0);
    reset    = 1'b0;
    BD_out_a = 1'b1;
    tick();
    chk("after_rst_in_a", 32'(PC_in_a), 32'd1);
    chk("after_rst_out_v", 32'(BD_out_v), 32'd0);
    tick();
    chk("stale_out_v", 32'(BD_out_v), 32'd0);
    chk("conf_cleared", 32'(conf_reg != '0), 32'd0);

    // Random traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      PC_in_v  = 1'($urandom_range(0, 1));
      BD_out_a = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) PC_in_d = 32'hFC000000;
      else PC_in_d = {5'($urandom_range(0, 30)), 27'($urandom)};
      tick();
    end
    PC_in_v  = 1'b0;
    BD_out_a = 1'b1;
    repeat (4) tick();
    chk("rand_drained", 32'(exp_q.size()), 32'd0);
    chk("rand_out_v_idle", 32'(BD_out_v), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
